// File: rtl/ni_inject_ctrl_pkg.sv
// ni_inject_ctrl_pkg: shared NoC injection parameters and flit type
package ni_inject_ctrl_pkg;
  localparam int FLIT_W = 20;
  localparam int PKT_LEN = 30;
  localparam int DEPTH = 32;
  localparam int CREDITS = 4;
  localparam int SKID = 3;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int IDX_W = $clog2(PKT_LEN);
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/ni_inject_ctrl_if.sv
// ni_inject_ctrl_if: source-side and router-side signal bundle of the injection stage
interface ni_inject_ctrl_if;
  import ni_inject_ctrl_pkg::*;
  flit_t in_data, flit_out;
  logic in_valid, inj_enable, flit_valid, flit_tail, credit_in, err_overflow, err_credit;
  logic [7:0] pkt_sent_cnt;
  modport master (
    output in_data, in_valid, credit_in,
    input  inj_enable, flit_out, flit_valid, flit_tail, pkt_sent_cnt, err_overflow, err_credit
  );
  modport slave (
    input  in_data, in_valid, credit_in,
    output inj_enable, flit_out, flit_valid, flit_tail, pkt_sent_cnt, err_overflow, err_credit
  );
endinterface

// File: rtl/ni_inject_ctrl_sync_fifo.sv
// ni_inject_ctrl_sync_fifo: register-array FIFO with extended pointers and occupancy count
module ni_inject_ctrl_sync_fifo #(
  parameter int DEPTH = 32,
  parameter int FLIT_W = 20,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_rd,
  output logic [FLIT_W-1:0] o_data,
  output logic [AW:0]       o_count,
  output logic              o_full,
  output logic              o_empty
);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  always_ff @(posedge clk)
    if (i_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  assign o_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full = o_count[AW];
  assign o_empty = o_count == '0;
endmodule

// File: rtl/ni_inject_ctrl.sv
// ni_inject_ctrl: credit-flow-controlled flit injection from source buffer into router local port
module ni_inject_ctrl
  import ni_inject_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  ni_inject_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] SKID_C = (AW+1)'(SKID);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CRED_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  flit_t w_head, r_flit;
  logic [AW:0] w_count, w_occ_next;
  logic w_full, w_empty, w_send, w_wr, w_ovf, w_last;
  logic [CNT_W-1:0] r_cred, w_cred_next;
  logic [IDX_W-1:0] r_idx;
  logic [7:0] r_pkt;
  logic r_inj, r_valid, r_tail, r_err_ovf, r_err_cred;
  ni_inject_ctrl_sync_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_fifo (
    .clk(clk), .rst(rst), .i_wr(w_wr), .i_data(bus.in_data), .i_rd(w_send),
    .o_data(w_head), .o_count(w_count), .o_full(w_full), .o_empty(w_empty)
  );
  always_comb begin
    w_send = !w_empty && r_cred != '0;
    w_wr = bus.in_valid && (!w_full || w_send);
    w_ovf = bus.in_valid && w_full && !w_send;
    w_last = r_idx == IDX_LAST;
    w_occ_next = w_count + (AW+1)'(w_wr) - (AW+1)'(w_send);
    w_cred_next = (w_send && !bus.credit_in) ? r_cred - CRED_ONE :
                  (bus.credit_in && !w_send && r_cred != CRED_MAX) ? r_cred + CRED_ONE : r_cred;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_inj <= 1'b0;
      r_flit <= '0;
      r_valid <= 1'b0;
      r_tail <= 1'b0;
      r_pkt <= '0;
      r_err_ovf <= 1'b0;
      r_err_cred <= 1'b0;
      r_cred <= CRED_MAX;
      r_idx <= '0;
    end else begin
      r_inj <= (DEPTH_C - w_occ_next) > SKID_C;
      r_valid <= w_send;
      r_tail <= w_send && w_last;
      r_cred <= w_cred_next;
      if (w_send) begin
        r_flit <= w_head;
        r_idx <= w_last ? '0 : r_idx + IDX_ONE;
        if (w_last) r_pkt <= r_pkt + 8'd1;
      end
      if (w_ovf) r_err_ovf <= 1'b1;
      if (bus.credit_in && !w_send && r_cred == CRED_MAX) r_err_cred <= 1'b1;
    end
  assign bus.inj_enable = r_inj;
  assign bus.flit_out = r_flit;
  assign bus.flit_valid = r_valid;
  assign bus.flit_tail = r_tail;
  assign bus.pkt_sent_cnt = r_pkt;
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_credit = r_err_cred;
endmodule
